// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Opcode encoding and opcode-class helpers shared by the arbiter and its users.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam logic [3:0] kADD  = 4'h0;
    localparam logic [3:0] kADDI = 4'h1;
    localparam logic [3:0] kSUB  = 4'h2;
    localparam logic [3:0] kAND  = 4'h3;
    localparam logic [3:0] kOR   = 4'h4;
    localparam logic [3:0] kXOR  = 4'h5;
    localparam logic [3:0] kNOT  = 4'h6;
    localparam logic [3:0] kLSH  = 4'h7;
    localparam logic [3:0] kRSH  = 4'h8;
    localparam logic [3:0] kSHLR = 4'h9;
    localparam logic [3:0] kCOMP = 4'hA;

    // One captured ALU command: opcode, operands and the requester that owns it.
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       owner;
    } alu_cmd_t;

    // Opcodes whose ALU carry/shift-out is architecturally visible.
    function automatic logic op_writes_carry(input logic [3:0] op);
        return (op == kADD) || (op == kADDI) || (op == kLSH) ||
               (op == kRSH) || (op == kSHLR);
    endfunction

    // Only the compare updates zero/greater; everything else leaves them alone.
    function automatic logic op_writes_cmp(input logic [3:0] op);
        return (op == kCOMP);
    endfunction

endpackage

// Two-requester arbiter in front of one shared combinational ALU, with flag registers.
// Latency: grant at N, ALU drive at N+1, registered response from N+2 until owner ack.
// Backpressure: req_ready only in IDLE; a pending response blocks all new grants.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_op0,
    input  logic [3:0] req_op1,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_b1,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_data,
    input  logic [1:0] rsp_ack,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sc_in,
    output logic       alu_zero_in,
    output logic       alu_greater_in,
    input  logic [7:0] alu_out,
    input  logic       alu_sc_out,
    input  logic       alu_zero,
    input  logic       alu_greater,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_g
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic       last_q;
    alu_cmd_t   cmd_q;
    alu_cmd_t   cmd_d;
    logic       grant_vld;
    logic       grant_idx;
    logic [7:0] rsp_data_q;
    logic       flag_c_q;
    logic       flag_z_q;
    logic       flag_g_q;

    // Pick a winner among valid requesters; only IDLE can accept work.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end
                2'b10: begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end
                2'b11: begin
                    grant_vld = 1'b1;
                    // Round-robin hands contention to whoever did not win last time.
                    grant_idx = FAIR ? ~last_q : 1'b0;
                end
                default: begin
                    grant_vld = 1'b0;
                    grant_idx = 1'b0;
                end
            endcase
        end
    end

    assign req_ready = {grant_vld & grant_idx, grant_vld & ~grant_idx};

    // Mux the winning requester's command into the capture format.
    always_comb begin
        cmd_d = '0;
        if (grant_idx) begin
            cmd_d.op    = req_op1;
            cmd_d.a     = req_a1;
            cmd_d.b     = req_b1;
            cmd_d.owner = 1'b1;
        end else begin
            cmd_d.op    = req_op0;
            cmd_d.a     = req_a0;
            cmd_d.b     = req_b0;
            cmd_d.owner = 1'b0;
        end
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the ALU drive and response-valid outputs.
    always_comb begin
        state_d   = state_q;
        alu_op    = 4'h0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_op  = cmd_q.op;
                alu_a   = cmd_q.a;
                alu_b   = cmd_q.b;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = cmd_q.owner ? 2'b10 : 2'b01;
                // Acks from the other requester are not ours to act on.
                if (rsp_ack[cmd_q.owner]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the granted command and remember the winner for round-robin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q  <= '0;
            last_q <= 1'b1;
        end else if (grant_vld) begin
            cmd_q  <= cmd_d;
            last_q <= grant_idx;
        end
    end

    // Register the ALU result and the opcode-qualified flags at the end of EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data_q <= 8'h00;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_g_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_data_q <= alu_out;
            if (op_writes_carry(cmd_q.op)) begin
                flag_c_q <= alu_sc_out;
            end
            if (op_writes_cmp(cmd_q.op)) begin
                flag_z_q <= alu_zero;
                flag_g_q <= alu_greater;
            end
        end
    end

    assign rsp_data       = rsp_data_q;
    assign flag_c         = flag_c_q;
    assign flag_z         = flag_z_q;
    assign flag_g         = flag_g_q;
    assign alu_sc_in      = flag_c_q;
    assign alu_zero_in    = flag_z_q;
    assign alu_greater_in = flag_g_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 REQ_VALID  input  2  bit i = requester i presents an operation.
REQ-005 REQ_READY  output  2  bit i = operation of requester i accepted this cycle.
REQ-006 REQ_OP0, REQ_OP1  input  4 each  ALU opcode (definitions package encoding).
REQ-007 REQ_A0, REQ_A1, REQ_B0, REQ_B1  input  8 each  operands A and B.
REQ-008 RSP_VALID  output  2  bit i = result for requester i available.
REQ-009 RSP_DATA  output  8  registered result.
REQ-010 RSP_ACK  input  2  bit i = requester i consumes its response.
REQ-011 ALU_OP  output  4;  ALU_A, ALU_B  output  8 each  operands to shared ALU.
REQ-012 ALU_SC_IN, ALU_ZERO_IN, ALU_GREATER_IN  output  1 each  flag feedback to ALU.
REQ-013 ALU_OUT  input  8;  ALU_SC_OUT, ALU_ZERO, ALU_GREATER  input  1 each  ALU results.
REQ-014 FLAG_C, FLAG_Z, FLAG_G  output  1 each  architectural carry/zero/greater flags.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on any accepted request, EXEC->RESP unconditionally, RESP->IDLE when RSP_ACK bit of the owning requester is 1.
REQ-016 REQ_READY SHALL be nonzero only in IDLE, at most one bit set (one-hot), combinationally from REQ_VALID and arbitration state.
REQ-017 Both valid with FAIR=1: grant the requester not granted last; LAST register resets to 1 so requester 0 wins first contention.
REQ-018 FAIR=0: requester 0 always wins contention; requester 1 granted only when REQ_VALID[0]=0.
REQ-019 Single valid requester SHALL be granted in IDLE regardless of LAST; LAST updates to the granted index on every grant.
REQ-020 On grant the opcode, A, B and owner index SHALL be registered; requesters must hold inputs stable until REQ_READY.
REQ-021 In EXEC, ALU_OP/ALU_A/ALU_B SHALL drive registered values; in IDLE and RESP they SHALL be 0.
REQ-022 ALU_SC_IN=FLAG_C, ALU_ZERO_IN=FLAG_Z, ALU_GREATER_IN=FLAG_G at all times.
REQ-023 At the EXEC->RESP edge, RSP_DATA SHALL capture ALU_OUT.
REQ-024 FLAG_C SHALL capture ALU_SC_OUT only for kADD, kADDI, kLSH, kRSH, kSHLR; unchanged otherwise.
REQ-025 FLAG_Z/FLAG_G SHALL capture ALU_ZERO/ALU_GREATER only for kCOMP; unchanged otherwise.
REQ-026 RSP_VALID SHALL be one-hot for the owner throughout RESP, 0 elsewhere; RSP_DATA stable while RSP_VALID set.
REQ-027 Latency: grant at cycle N, EXEC at N+1, RSP_VALID from N+2; ACK in the first RESP cycle permits a new grant at N+3.
REQ-028 RSP_ACK of a non-owner, or in IDLE/EXEC, SHALL be ignored.
REQ-029 Requests arriving outside IDLE SHALL wait (READY=0) without loss; owner may re-request while its response is pending.
REQ-030 Undefined opcodes SHALL execute normally (result from ALU), flags unchanged.

Reset
REQ-031 RESET_N low SHALL immediately force: state IDLE, LAST=1, RSP_VALID=0, RSP_DATA=0, FLAG_C/Z/G=0, registered op/operands/owner=0.
REQ-032 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response issued after release.
REQ-033 First grant possible in the first rising edge with RESET_N high.

Verification
REQ-034 Req0 kADD A=8'h05 B=8'h03, FLAG_C=0 -> READY=2'b01 cycle N, RSP_VALID=2'b01 RSP_DATA=8'h08 at N+2.
REQ-035 Both valid continuously, FAIR=1, immediate ACKs -> grants alternate 0,1,0,1; FAIR=0 -> requester 0 every grant.
REQ-036 kCOMP A=8'h07 B=8'h07 -> FLAG_Z=1, FLAG_G=0, RSP_DATA=0; following kXOR leaves FLAG_Z=1.
REQ-037 Withhold RSP_ACK 5 cycles with req1 valid -> RSP_VALID/RSP_DATA held, REQ_READY=0 throughout, req1 granted cycle after ACK.
REQ-038 Assert RESET_N=0 during EXEC -> RSP_VALID never rises for that op, flags 0, LAST=1.
REQ-039 RSP_ACK=2'b10 while owner is 0 -> remains in RESP, RSP_VALID=2'b01.
